shiftb_arb: RTL and testbench

//   Shares one barrel shifter (left / logical right / arithmetic right)

---
 rtl/shiftb_arb.sv | 107 ++++++++++
 tb/tb_shiftb_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftb_arb.sv
// Round-robin arbitrated barrel shifter: NREQ valid/ready request ports share one
// shifter whose tagged result sits in a single-entry valid/ready output register.
module shiftb_arb #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*DW-1:0]            req_a,
  input  logic [NREQ*$clog2(DW)-1:0]    req_b,
  input  logic [NREQ-1:0]               req_dir,
  input  logic [NREQ-1:0]               req_arith,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DW-1:0]                 rsp_out,
  output logic [$clog2(NREQ)-1:0]       rsp_id
);

  localparam int unsigned SW = $clog2(DW);
  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt;
  logic          found;
  logic          free;
  logic          xfer;
  int unsigned   idx;
  int unsigned   nxt;

  logic [DW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic          sel_dir;
  logic          sel_arith;
  logic [DW-1:0] shift_res;

  assign free = !rsp_valid || rsp_ready;
  assign xfer = found && free;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end

  // Ready is forced low while reset is held, independent of the clock.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = nreset && xfer && (gnt == IW'(i));
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_dir   = 1'b0;
    sel_arith = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt == IW'(i)) begin
        sel_a     = req_a[i*DW +: DW];
        sel_b     = req_b[i*SW +: SW];
        sel_dir   = req_dir[i];
        sel_arith = req_arith[i];
      end
    end
  end

  always_comb begin
    shift_res = '0;
    if (!sel_dir) begin
      shift_res = sel_a << sel_b;
    end else if (sel_arith) begin
      shift_res = $signed(sel_a) >>> sel_b;
    end else begin
      shift_res = sel_a >> sel_b;
    end
  end

  assign nxt = (32'(gnt) + 1) % NREQ;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_out   <= shift_res;
      rsp_id    <= gnt;
      rr_ptr    <= IW'(nxt);
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shiftb_arb.sv
// Self-checking bench for shiftb_arb: table-driven shift vectors, directed
// arbitration/back-pressure sequences and a randomized scoreboard run.
module tb_shiftb_arb;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int SW = 5;

  logic             clk = 1'b0;
  logic             nreset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*SW-1:0] req_b;
  logic [NR-1:0]    req_dir;
  logic [NR-1:0]    req_arith;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_out;
  logic [1:0]       rsp_id;

  logic [DW-1:0] a_arr [NR];
  logic [SW-1:0] b_arr [NR];

  typedef struct packed {
    logic [DW-1:0] out;
    logic [1:0]    id;
  } rsp_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [SW-1:0] b;
    logic          dir;
    logic          arith;
    logic [DW-1:0] exp;
  } vec_t;

  rsp_t        q[$];
  int          m_ptr;
  int          wait_cnt [NR];
  logic [NR-1:0] last_ready;
  int          n_checks = 0;
  int          n_fail   = 0;

  shiftb_arb #(.DW(DW), .NREQ(NR)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_dir   (req_dir),
    .req_arith (req_arith),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = a_arr[i];
      req_b[i*SW +: SW] = b_arr[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift built from masks rather than the signed shift operator.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] a, input logic [SW-1:0] b,
                                              input logic dir, input logic arith);
    logic [DW-1:0] ones;
    ones = '1;
    if (!dir) return a << b;
    if (arith && a[DW-1]) return (a >> b) | ~(ones >> b);
    return a >> b;
  endfunction

  // Called at a falling edge with inputs already applied; compares, updates the
  // model, and advances to the next falling edge.
  task automatic step();
    logic          free;
    logic [NR-1:0] exp_ready;
    int            g;
    rsp_t          r;
    #1;
    free = (q.size() == 0) || rsp_ready;
    g = -1;
    for (int k = 0; k < NR; k++)
      if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    exp_ready = '0;
    if (free && g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
    check("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("rsp_out", 64'(rsp_out), 64'(q[0].out));
      check("rsp_id", 64'(rsp_id), 64'(q[0].id));
    end
    if (q.size() != 0 && rsp_ready) void'(q.pop_front());
    if (exp_ready != 0) begin
      r.out = ref_shift(a_arr[g], b_arr[g], req_dir[g], req_arith[g]);
      r.id  = 2'(g);
      q.push_back(r);
      m_ptr = (g + 1) % NR;
      check("grant_wait", 64'(wait_cnt[g] < NR), 64'd1);
      for (int i = 0; i < NR; i++) begin
        if (i == g || !req_valid[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
      end
    end
    last_ready = exp_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    last_ready = '0;
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{a: 32'h8000_00F0, b: 5'd4,  dir: 1'b0, arith: 1'b0, exp: 32'h0000_0F00};
    vecs[1] = '{a: 32'h8000_00F0, b: 5'd4,  dir: 1'b1, arith: 1'b0, exp: 32'h0800_000F};
    vecs[2] = '{a: 32'h8000_00F0, b: 5'd4,  dir: 1'b1, arith: 1'b1, exp: 32'hF800_000F};
    vecs[3] = '{a: 32'h8000_00F0, b: 5'd31, dir: 1'b1, arith: 1'b1, exp: 32'hFFFF_FFFF};

    model_reset();
    nreset    = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_dir   = '0;
    req_arith = '0;
    for (int i = 0; i < NR; i++) begin
      a_arr[i] = 32'h1111_1111 * (i + 1);
      b_arr[i] = 5'(i + 1);
    end
    #3;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_out", 64'(rsp_out), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    nreset = 1'b1;

    // Reset asserted while a result is held under back-pressure.
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1111;
    step();
    step();
    check("hold_before_rst", 64'(rsp_valid), 64'd1);
    nreset = 1'b0;
    #1;
    check("async_rst_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_out", 64'(rsp_out), 64'd0);
    check("async_rst_id", 64'(rsp_id), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(negedge clk);
    nreset = 1'b1;

    // Round-robin with all requesters valid and no back-pressure.
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_id", 64'(rsp_id), 64'(k % NR));
      check("rr_valid", 64'(rsp_valid), 64'd1);
    end

    // Stall with a result from requester 1, then release.
    req_valid = 4'b0010;
    step();
    check("stall_src", 64'(rsp_id), 64'd1);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_id", 64'(rsp_id), 64'd1);
      check("stall_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", 64'(req_ready), 64'b0100);
    step();
    check("release_id", 64'(rsp_id), 64'd2);

    // Drain and accept in the same cycle.
    req_valid = 4'b1000;
    #1;
    check("dna_ready", 64'(req_ready), 64'b1000);
    step();
    check("dna_id", 64'(rsp_id), 64'd3);
    check("dna_valid", 64'(rsp_valid), 64'd1);

    // Shift operations from requester 2.
    req_valid = 4'b0100;
    for (int v = 0; v < 4; v++) begin
      a_arr[2]     = vecs[v].a;
      b_arr[2]     = vecs[v].b;
      req_dir[2]   = vecs[v].dir;
      req_arith[2] = vecs[v].arith;
      step();
      check("op_out", 64'(rsp_out), 64'(vecs[v].exp));
      check("op_id", 64'(rsp_id), 64'd2);
    end

    // Randomized traffic; requests stay stable until accepted.
    req_valid = '0;
    step();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || last_ready[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          a_arr[i]     = $urandom;
          b_arr[i]     = 5'($urandom_range(0, 31));
          req_dir[i]   = 1'($urandom_range(0, 1));
          req_arith[i] = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    check("final_empty", 64'(rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
